sha256_digest_serializer: RTL and testbench
===========================================

Name: sha256_digest_serializer

Overview:
- Consumes the result side of the sha256 core: one-cycle ivalid pulses carrying id, message length and 256-bit digest.
- The sha256 result port has no backpressure, so each result is captured into an internal FIFO.
- Each buffered result is re-emitted as a byte-wide valid/ready stream frame (digest MSB byte first, tlast on final byte) toward a host/UART/DMA link.

Parameters:
- DEPTH, 4, result FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ivalid  in  1  result strobe (connect to sha256 ovalid)
- iid  in  32  frame id (oid)
- ilen  in  61  message length in bytes (olen)
- isha  in  256  digest (osha)
- m_tvalid  out  1  output byte valid
- m_tready  in  1  output byte ready
- m_tlast  out  1  last byte of frame
- m_tid  out  32  frame id, constant across frame
- m_tdata  out  8  output byte
- overflow  out  1  sticky: a result was dropped
- drop_cnt  out  16  dropped-result count, saturating
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the frame currently in the shift register

Behaviour:
- Reset (async, active-high): m_tvalid=0, m_tlast=0, m_tid=0, m_tdata=0, overflow=0, drop_cnt=0, fifo_level=0. FIFO emptied; FSM to IDLE. A frame in flight is discarded with no tlast.
- FIFO write: on ivalid, if count<DEPTH or a pop occurs in the same cycle. Otherwise the result is dropped: overflow<=1, drop_cnt<=drop_cnt+1, saturating at 16'hFFFF.
- FSM states IDLE, SEND.
- IDLE: if FIFO non-empty, pop head into shift register {id, len, sha}, byte_idx<=0, m_tvalid<=1, go to SEND.
- Latency: ivalid at cycle N gives first m_tvalid at N+2 when idle.
- SEND: the handshake is m_tvalid&&m_tready. On each handshake, shift left 8 and byte_idx++.
- m_tlast=1 exactly when byte_idx==NBYTES-1, where NBYTES=32 (40 with header).
- On the last-byte handshake: if FIFO non-empty, reload immediately with no bubble (m_tvalid stays 1); else m_tvalid<=0 and go to IDLE.
- While m_tvalid && !m_tready, m_tdata, m_tlast and m_tid are held stable.
- m_tdata = shift[top byte]. Digest byte order: isha[255:248] first, isha[7:0] last.
- Simultaneous ivalid and pop while full: write accepted, count unchanged.
- Effective buffering is DEPTH+1 (FIFO plus shift register).
- FIFO pointers wrap modulo DEPTH; count is 0..DEPTH.

Optional Feature:
- Macro SHA_SER_LEN_HDR_EN.
- Defined: each frame is prefixed with 8 bytes of length, {3'b0, ilen} big-endian, so the frame is 40 bytes with tlast on byte 40. The shift register widens to 320 bits plus id.
- Undefined: the length is not stored in the FIFO and the frame is 32 bytes.

Decomposition:
- Package sha_ser_pkg:
  - typedef struct packed sha_rec_t {id[31:0], len[60:0], sha[255:0]}
  - localparams DIGEST_BYTES=32, LEN_HDR_BYTES=8
  - function frame_bytes()
- Sub-module sha_ser_fifo: synchronous FIFO of sha_rec_t, same async reset. Provides wr_en, rd_en, full, empty, count.
- Top module holds the FSM, shift register and drop counter.

Test Plan:
- Single frame, m_tready=1: ivalid id=111, len=3, sha=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - Required: first m_tvalid 2 cycles later; 32 consecutive bytes ba,78,16,bf,…,00,15,ad; m_tid=111 throughout; m_tlast only on byte 32 (ad).
- Backpressure: same input, m_tready random 20% duty.
  - Required: identical byte sequence; data/last/id held whenever valid&&!ready; no byte lost or duplicated.
- Back-to-back frames: ids 222 and 333 pushed 1 cycle apart, m_tready=1.
  - Required: 64 contiguous valid bytes with no bubble; tid switches 222→333 on byte 33; two tlast pulses.
- Overflow, DEPTH=4, m_tready=0: six ivalid pulses on consecutive cycles, ids 1..6.
  - Required: fifo_level=4; overflow=1; drop_cnt=1.
  - Then m_tready=1: frames emitted in order ids 1,2,3,4,5; id 6 never appears.
- Reset mid-frame: assert rst after byte 10 of id 444 with the FIFO holding one more result.
  - Required: m_tvalid=0 immediately (asynchronous); fifo_level=0; no further output after release.
- With SHA_SER_LEN_HDR_EN: id=555, len=3, abc digest.
  - Required: bytes 00,00,00,00,00,00,00,03 then ba…ad; m_tlast on byte 40.

Source files
------------

// File: rtl/sha_ser_pkg.sv
// Shared types and frame geometry for the SHA-256 digest serializer.
// Build option: SHA_SER_LEN_HDR_EN prefixes each frame with an 8-byte
// big-endian length header.
package sha_ser_pkg;

  localparam int DIGEST_BYTES  = 32;
  localparam int LEN_HDR_BYTES = 8;

`ifdef SHA_SER_LEN_HDR_EN
  localparam int FRAME_BYTES = DIGEST_BYTES + LEN_HDR_BYTES;
`else
  localparam int FRAME_BYTES = DIGEST_BYTES;
`endif

  // Width of the byte index; large enough for either frame size.
  localparam int IDX_W = 6;

  typedef struct packed {
    logic [31:0]  id;
    logic [60:0]  len;
    logic [255:0] sha;
  } sha_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  function automatic int frame_bytes();
    return FRAME_BYTES;
  endfunction

endpackage

// File: rtl/sha_ser_fifo.sv
// Result FIFO for the digest serializer. Holds sha_rec_t entries; a write
// into a full FIFO is only accepted when a read happens in the same cycle.
module sha_ser_fifo
  import sha_ser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  sha_rec_t               wr_data,
  input  logic                   rd_en,
  output sha_rec_t               rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  sha_rec_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            wr_ok, rd_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers/occupancy.
  always_comb begin
    rd_ok    = rd_en && !empty;
    wr_ok    = wr_en && (!full || rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/sha256_digest_serializer.sv
// Buffers SHA-256 results and re-emits each as a byte stream frame,
// digest MSB byte first, tlast on the final byte.
// Build option: SHA_SER_LEN_HDR_EN adds an 8-byte length header per frame.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | shift register empty, waiting for a buffered result
// SEND    | frame loaded, presenting bytes on m_tdata
module sha256_digest_serializer
  import sha_ser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ivalid,
  input  logic [31:0]            iid,
  input  logic [60:0]            ilen,
  input  logic [255:0]           isha,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [31:0]            m_tid,
  output logic [7:0]             m_tdata,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int SW = FRAME_BYTES * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  ser_state_e       state_q, state_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic [31:0]      tid_q, tid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tvalid_q, tvalid_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  sha_rec_t         wr_rec;
  sha_rec_t         head;
  logic [SW-1:0]    head_frame;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             handshake, at_last, drop;

  assign wr_rec.id  = iid;
  assign wr_rec.sha = isha;
`ifdef SHA_SER_LEN_HDR_EN
  assign wr_rec.len = ilen;
  assign head_frame = {3'b000, head.len, head.sha};
`else
  // Length is not part of the frame; tie it off so the FIFO bits vanish.
  logic len_unused;
  assign wr_rec.len = '0;
  assign head_frame = head.sha;
  assign len_unused = ^{ilen, head.len};
`endif

  assign handshake = tvalid_q && m_tready;
  assign at_last   = (idx_q == LAST_IDX);
  // A result is only lost when the FIFO is full and nothing leaves this cycle.
  assign fifo_push = ivalid && (!fifo_full || fifo_pop);
  assign drop      = ivalid && fifo_full && !fifo_pop;

  sha_ser_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_push),
    .wr_data (wr_rec),
    .rd_en   (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_level)
  );

  // Frame FSM: load from FIFO, shift a byte per handshake, reload without a bubble.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    tid_d    = tid_q;
    idx_d    = idx_q;
    tvalid_d = tvalid_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = head_frame;
          tid_d    = head.id;
          idx_d    = '0;
          tvalid_d = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (at_last) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = head_frame;
              tid_d    = head.id;
              idx_d    = '0;
            end else begin
              shift_d  = '0;
              idx_d    = '0;
              tvalid_d = 1'b0;
              state_d  = ST_IDLE;
            end
          end else begin
            shift_d = {shift_q[SW-9:0], 8'h00};
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      tid_q      <= '0;
      idx_q      <= '0;
      tvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tid_q      <= tid_d;
      idx_q      <= idx_d;
      tvalid_q   <= tvalid_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign m_tvalid = tvalid_q;
  assign m_tlast  = tvalid_q && at_last;
  assign m_tid    = tid_q;
  assign m_tdata  = shift_q[SW-1 -: 8];
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Self-checking bench for sha256_digest_serializer (scoreboard of expected bytes).
module tb_sha256_digest_serializer;

  localparam int DEPTH = 4;
`ifdef SHA_SER_LEN_HDR_EN
  localparam int NB = 40;
`else
  localparam int NB = 32;
`endif
  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   ivalid = 1'b0;
  logic [31:0]            iid = '0;
  logic [60:0]            ilen = '0;
  logic [255:0]           isha = '0;
  logic                   m_tvalid;
  logic                   m_tready = 1'b0;
  logic                   m_tlast;
  logic [31:0]            m_tid;
  logic [7:0]             m_tdata;
  logic                   overflow;
  logic [15:0]            drop_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  sha256_digest_serializer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ivalid     (ivalid),
    .iid        (iid),
    .ilen       (ilen),
    .isha       (isha),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tid      (m_tid),
    .m_tdata    (m_tdata),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id;
    logic [7:0]  data;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passed = 0;
  int          tlast_seen = 0;
  bit          stall_q = 1'b0;
  logic [7:0]  hold_d;
  logic        hold_l;
  logic [31:0] hold_id;

  task automatic push_expected(input logic [31:0] id, input logic [60:0] len,
                               input logic [255:0] sha);
    exp_t e;
    logic [63:0] hdr;
    hdr = {3'b000, len};
    e.id = id;
`ifdef SHA_SER_LEN_HDR_EN
    for (int i = 0; i < 8; i++) begin
      e.data = hdr[63-8*i -: 8];
      e.last = 1'b0;
      sb_q.push_back(e);
    end
`endif
    for (int i = 0; i < 32; i++) begin
      e.data = sha[255-8*i -: 8];
      e.last = (i == 31);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: pop the scoreboard on each handshake, check hold during stalls.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          checks++;
          if (m_tvalid !== 1'b1 || m_tdata !== hold_d || m_tlast !== hold_l || m_tid !== hold_id)
            $display("FAIL hold: got v=%b d=%h l=%b id=%0d want v=1 d=%h l=%b id=%0d",
                     m_tvalid, m_tdata, m_tlast, m_tid, hold_d, hold_l, hold_id);
          else passed++;
        end
        if (m_tvalid && m_tready) begin
          checks++;
          if (sb_q.size() == 0) begin
            $display("FAIL unexpected_byte: got d=%h id=%0d want no output", m_tdata, m_tid);
          end else begin
            e = sb_q.pop_front();
            if (m_tdata !== e.data || m_tlast !== e.last || m_tid !== e.id)
              $display("FAIL byte: got d=%h l=%b id=%0d want d=%h l=%b id=%0d",
                       m_tdata, m_tlast, m_tid, e.data, e.last, e.id);
            else passed++;
          end
          if (m_tlast) tlast_seen++;
        end
        stall_q = m_tvalid && !m_tready;
        hold_d  = m_tdata;
        hold_l  = m_tlast;
        hold_id = m_tid;
      end
    end
  end

  task automatic wait_drain(input int budget, input bit rnd);
    int n = 0;
    while ((sb_q.size() != 0 || m_tvalid) && n < budget) begin
      @(posedge clk); #1;
      if (rnd) m_tready = ($urandom_range(0, 4) == 0);
      n++;
    end
    m_tready = 1'b1;
    checks++;
    if (sb_q.size() != 0 || m_tvalid)
      $display("FAIL drain: got %0d bytes pending, valid=%b want 0 pending", sb_q.size(), m_tvalid);
    else passed++;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_tvalid); else passed++;
    checks++; if (m_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_tlast); else passed++;
    checks++; if (m_tid !== 32'd0) $display("FAIL rst_tid: got %0d want 0", m_tid); else passed++;
    checks++; if (m_tdata !== 8'd0) $display("FAIL rst_tdata: got %h want 00", m_tdata); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else passed++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); else passed++;
    checks++; if (fifo_level !== '0) $display("FAIL rst_level: got %0d want 0", fifo_level); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int t0;
    t0 = tlast_seen;
    m_tready = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b1; iid = 32'd111; ilen = 61'd3; isha = ABC;
    push_expected(32'd111, 61'd3, ABC);
    @(posedge clk); #1;
    ivalid = 1'b0;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL latency_early: got valid=%b want 0", m_tvalid); else passed++;
    @(posedge clk); #1;
    checks++; if (m_tvalid !== 1'b1) $display("FAIL latency: got valid=%b want 1", m_tvalid); else passed++;
    wait_drain(500, 1'b0);
    checks++; if (tlast_seen - t0 !== 1) $display("FAIL single_tlast: got %0d want 1", tlast_seen - t0); else passed++;
  endtask

  task automatic test_backpressure();
    int t0;
    t0 = tlast_seen;
    m_tready = 1'b0;
    @(posedge clk); #1;
    ivalid = 1'b1; iid = 32'd111; ilen = 61'd3; isha = ABC;
    push_expected(32'd111, 61'd3, ABC);
    @(posedge clk); #1;
    ivalid = 1'b0;
    wait_drain(3000, 1'b1);
    checks++; if (tlast_seen - t0 !== 1) $display("FAIL bp_tlast: got %0d want 1", tlast_seen - t0); else passed++;
  endtask

  task automatic test_back_to_back();
    int t0, run, n;
    t0 = tlast_seen;
    m_tready = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b1; iid = 32'd222; ilen = 61'd3; isha = ABC;
    push_expected(32'd222, 61'd3, ABC);
    @(posedge clk); #1;
    iid = 32'd333; ilen = 61'd7; isha = ~ABC;
    push_expected(32'd333, 61'd7, ~ABC);
    @(posedge clk); #1;
    ivalid = 1'b0;
    n = 0;
    while (!m_tvalid && n < 10) begin @(posedge clk); #1; n++; end
    run = 0;
    while (m_tvalid && run < 200) begin run++; @(posedge clk); #1; end
    checks++; if (run !== 2 * NB) $display("FAIL b2b_run: got %0d valid cycles want %0d", run, 2 * NB); else passed++;
    wait_drain(500, 1'b0);
    checks++; if (tlast_seen - t0 !== 2) $display("FAIL b2b_tlast: got %0d want 2", tlast_seen - t0); else passed++;
  endtask

  task automatic test_overflow();
    int t0;
    logic [255:0] sha;
    t0 = tlast_seen;
    m_tready = 1'b0;
    @(posedge clk); #1;
    for (int id = 1; id <= 6; id++) begin
      sha = ABC ^ {8{32'(id)}};
      ivalid = 1'b1; iid = 32'(id); ilen = 61'(id); isha = sha;
      if (id <= 5) push_expected(32'(id), 61'(id), sha);
      @(posedge clk); #1;
    end
    ivalid = 1'b0;
    @(posedge clk); #1;
    checks++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d want 4", fifo_level); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passed++;
    checks++; if (drop_cnt !== 16'd1) $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); else passed++;
    m_tready = 1'b1;
    wait_drain(2000, 1'b0);
    checks++; if (tlast_seen - t0 !== 5) $display("FAIL ovf_frames: got %0d want 5", tlast_seen - t0); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int hs, n, v;
    m_tready = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b1; iid = 32'd444; ilen = 61'd3; isha = ABC;
    push_expected(32'd444, 61'd3, ABC);
    @(posedge clk); #1;
    iid = 32'd445; isha = ~ABC;
    push_expected(32'd445, 61'd3, ~ABC);
    @(posedge clk); #1;
    ivalid = 1'b0;
    hs = 0; n = 0;
    while (hs < 10 && n < 200) begin
      @(negedge clk);
      if (m_tvalid && m_tready) hs++;
      n++;
    end
    @(posedge clk); #2;
    checks++; if (fifo_level !== 3'd1) $display("FAIL pre_rst_level: got %0d want 1", fifo_level); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL mid_rst_tvalid: got %b want 0", m_tvalid); else passed++;
    checks++; if (fifo_level !== '0) $display("FAIL mid_rst_level: got %0d want 0", fifo_level); else passed++;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0)
      $display("FAIL mid_rst_status: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt);
    else passed++;
    sb_q.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    v = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (m_tvalid) v++;
    end
    checks++; if (v !== 0) $display("FAIL post_rst_output: got %0d valid cycles want 0", v); else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
